// File: rtl/mux10_rr_arbiter_if.sv
// Channel bundle between the ten lane sources, the round-robin arbiter and
// the single downstream consumer. The arbiter drives the master side; lane
// sources and the consumer sit on the slave side.
interface mux10_rr_arbiter_if #(
    parameter int N    = 10,
    parameter int W    = 8,
    parameter int SELW = 4
);
    logic [N-1:0]    req;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;

    modport master (
        input  req,
        input  in_data,
        input  out_ready,
        output ack,
        output gnt,
        output sel,
        output out_valid,
        output out_data
    );

    modport slave (
        output req,
        output in_data,
        output out_ready,
        input  ack,
        input  gnt,
        input  sel,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/mux10_rr_arbiter.sv
// Round-robin, burst-limited arbiter owning the select of a 10:1 x 8-bit mux.
// A single registered grant drives sel; the selected lane is presented on a
// valid/ready port and the owning lane is popped through a one-hot ack.
// When a grant ends, the search restarts just after the previous owner, so
// the owner only wins again when it is the sole requester.
module mux10_rr_arbiter #(
    parameter int N         = 10,
    parameter int W         = 8,
    parameter int SELW      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux10_rr_arbiter_if.master bus
);

    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [SELW-1:0] sel_r;
    logic [SELW-1:0] sel_s;
    logic [N-1:0]    gnt_r;
    logic [N-1:0]    gnt_s;
    logic            out_valid_r;
    logic            out_valid_s;
    logic [CNTW-1:0] burst_cnt_r;
    logic [CNTW-1:0] burst_cnt_s;
    logic [SELW-1:0] ptr_r;
    logic [SELW-1:0] ptr_s;

    logic [SELW:0]   idle_pick_s;
    logic [SELW:0]   rot_pick_s;
    logic [SELW-1:0] rot_ptr_s;
    logic            xfer_s;
    logic            last_beat_s;
    logic            owner_req_s;
    logic [W-1:0]    out_data_s;
    logic [N-1:0]    ack_s;

    // Lane index following idx, wrapping 9 -> 0.
    function automatic logic [SELW-1:0] next_lane(input logic [SELW-1:0] idx);
        logic [SELW-1:0] nxt;
        if (idx >= SELW'(N - 1)) begin
            nxt = {SELW{1'b0}};
        end else begin
            nxt = idx + SELW'(1);
        end
        return nxt;
    endfunction

    // One-hot lane vector for lane idx.
    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // First requester found walking start, start+1, ... modulo N.
    // Result is {found, lane}. Walking the order backwards lets the
    // highest-priority hit be the last one written.
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0]    r,
                                              input logic [SELW-1:0] start);
        logic            found;
        logic [SELW-1:0] pick;
        logic [SELW-1:0] idx;
        found = 1'b0;
        pick  = {SELW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (int'(start) + i >= N) begin
                idx = SELW'(int'(start) + i - N);
            end else begin
                idx = SELW'(int'(start) + i);
            end
            if (r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    assign idle_pick_s = rr_pick(bus.req, ptr_r);
    assign rot_ptr_s   = next_lane(sel_r);
    assign rot_pick_s  = rr_pick(bus.req, rot_ptr_s);
    assign xfer_s      = out_valid_r & bus.out_ready;
    assign last_beat_s = (burst_cnt_r == CNTW'(MAX_BURST - 1));
    assign owner_req_s = bus.req[sel_r];

    // Next-state and next-grant decision for the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        gnt_s       = gnt_r;
        out_valid_s = out_valid_r;
        burst_cnt_s = burst_cnt_r;
        ptr_s       = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[SELW]) begin
                    state_s     = ST_GRANT;
                    sel_s       = idle_pick_s[SELW-1:0];
                    gnt_s       = onehot(idle_pick_s[SELW-1:0]);
                    out_valid_s = 1'b1;
                    burst_cnt_s = {CNTW{1'b0}};
                end else begin
                    state_s     = ST_IDLE;
                    gnt_s       = {N{1'b0}};
                    out_valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (xfer_s && owner_req_s && !last_beat_s) begin
                    // Burst continues with the same owner.
                    burst_cnt_s = burst_cnt_r + CNTW'(1);
                end else if (xfer_s || !owner_req_s) begin
                    // Burst finished, owner ran dry, or owner withdrew:
                    // rotate and hand over in the same edge.
                    ptr_s = rot_ptr_s;
                    if (rot_pick_s[SELW]) begin
                        state_s     = ST_GRANT;
                        sel_s       = rot_pick_s[SELW-1:0];
                        gnt_s       = onehot(rot_pick_s[SELW-1:0]);
                        out_valid_s = 1'b1;
                        burst_cnt_s = {CNTW{1'b0}};
                    end else begin
                        state_s     = ST_IDLE;
                        gnt_s       = {N{1'b0}};
                        out_valid_s = 1'b0;
                        burst_cnt_s = {CNTW{1'b0}};
                    end
                end else begin
                    // Consumer stalled: hold everything, no timeout.
                    state_s = ST_GRANT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_s       = {N{1'b0}};
                out_valid_s = 1'b0;
                burst_cnt_s = {CNTW{1'b0}};
            end
        endcase
    end

    // Arbitration state, grant and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SELW{1'b0}};
            gnt_r       <= {N{1'b0}};
            out_valid_r <= 1'b0;
            burst_cnt_r <= {CNTW{1'b0}};
            ptr_r       <= {SELW{1'b0}};
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            gnt_r       <= gnt_s;
            out_valid_r <= out_valid_s;
            burst_cnt_r <= burst_cnt_s;
            ptr_r       <= ptr_s;
        end
    end

    // The 10:1 data mux steered by the registered select; codes 10..15 never occur.
    always_comb begin
        out_data_s = {W{1'b0}};
        case (sel_r)
            4'd0:    out_data_s = bus.in_data[0*W +: W];
            4'd1:    out_data_s = bus.in_data[1*W +: W];
            4'd2:    out_data_s = bus.in_data[2*W +: W];
            4'd3:    out_data_s = bus.in_data[3*W +: W];
            4'd4:    out_data_s = bus.in_data[4*W +: W];
            4'd5:    out_data_s = bus.in_data[5*W +: W];
            4'd6:    out_data_s = bus.in_data[6*W +: W];
            4'd7:    out_data_s = bus.in_data[7*W +: W];
            4'd8:    out_data_s = bus.in_data[8*W +: W];
            4'd9:    out_data_s = bus.in_data[9*W +: W];
            default: out_data_s = {W{1'b0}};
        endcase
    end

    assign ack_s         = gnt_r & {N{xfer_s}};
    assign bus.ack       = ack_s;
    assign bus.gnt       = gnt_r;
    assign bus.sel       = sel_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_s;

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Directed bench for mux10_rr_arbiter. Stimulus pushes the expected beats
// (lane, data) into a scoreboard queue; a negedge monitor pops and compares
// on every out_valid & out_ready cycle.
module tb_mux10_rr_arbiter;

    logic clk;
    logic rst_n;

    mux10_rr_arbiter_if #(.N(10), .W(8), .SELW(4)) bus ();

    mux10_rr_arbiter #(.N(10), .W(8), .SELW(4), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] lane;
        logic [7:0] data;
    } beat_t;

    beat_t      sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] lane_val [10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] lane_bit(input logic [3:0] lane);
        logic [9:0] one;
        one = 10'd1;
        return one << lane;
    endfunction

    task automatic push_beats(input logic [3:0] lane, input int count);
        beat_t b;
        b.lane = lane;
        b.data = lane_val[lane];
        for (int i = 0; i < count; i++) sb_q.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic stop_traffic();
        bus.req       = 10'h000;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        stop_traffic();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted beat must match the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: got sel=%0d data=%0d, expected no transfer at %0t",
                         bus.sel, bus.out_data, $time);
            end else begin
                e = sb_q.pop_front();
                check("beat_sel",  32'(bus.sel),      32'(e.lane));
                check("beat_data", 32'(bus.out_data), 32'(e.data));
                check("beat_ack",  32'(bus.ack),      32'(lane_bit(e.lane)));
                check("beat_gnt",  32'(bus.gnt),      32'(lane_bit(e.lane)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        lane_val = '{8'd1, 8'd12, 8'd51, 8'd47, 8'd22, 8'd17, 8'd83, 8'd104, 8'd7, 8'd21};
        for (int i = 0; i < 10; i++) bus.in_data[i*8 +: 8] = lane_val[i];
        bus.req       = 10'h000;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_gnt",   32'(bus.gnt),       32'h0);
        check("rst_sel",   32'(bus.sel),       32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_ack",   32'(bus.ack),       32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single requester lane 0, bursts back to back across the limit
        bus.out_ready = 1'b1;
        bus.req       = 10'h001;
        check("t1_valid_pre", 32'(bus.out_valid), 32'h0);
        push_beats(4'd0, 6);
        @(posedge clk);
        #1;
        check("t1_valid_lat", 32'(bus.out_valid), 32'h1);
        check("t1_sel",       32'(bus.sel),       32'h0);
        wait_drain("t1_drain", 20);
        #1 stop_traffic();
        repeat (2) @(posedge clk);
        #1 check("t1_idle", 32'(bus.out_valid), 32'h0);

        // 2: all lanes requesting, 4 beats each, wrap to lane 0, no bubbles
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 10'h3FF;
        for (int l = 0; l < 10; l++) push_beats(4'(l), 4);
        push_beats(4'd0, 4);
        @(posedge clk);
        repeat (44) @(posedge clk);
        #1 check("t2_no_bubble", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        stop_traffic();

        // 3: lane 9 owner, {9,0,3} pending -> 9, 0, 3
        do_reset();
        bus.req = 10'h200;
        @(posedge clk);
        #1 check("t3_sel9", 32'(bus.sel), 32'h9);
        bus.req       = 10'h209;
        bus.out_ready = 1'b1;
        push_beats(4'd9, 4);
        push_beats(4'd0, 4);
        push_beats(4'd3, 4);
        wait_drain("t3_drain", 30);
        #1 stop_traffic();
        repeat (2) @(posedge clk);

        // 4: consumer stall during lane 6 grant
        do_reset();
        bus.req = 10'h040;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_sel",   32'(bus.sel),       32'h6);
            check("t4_data",  32'(bus.out_data),  32'd83);
            check("t4_valid", 32'(bus.out_valid), 32'h1);
            check("t4_ack",   32'(bus.ack),       32'h0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push_beats(4'd6, 2);
        wait_drain("t4_drain", 10);
        #1 stop_traffic();
        repeat (2) @(posedge clk);

        // 5: owner lane 2 withdraws without transfer -> next lane >= 3 (7)
        do_reset();
        bus.req = 10'h004;
        @(posedge clk);
        #1 check("t5_gnt2", 32'(bus.gnt), 32'h004);
        bus.req = 10'h082;
        @(negedge clk);
        check("t5_no_ack", 32'(bus.ack), 32'h0);
        @(posedge clk);
        #1;
        check("t5_gnt7",   32'(bus.gnt),       32'h080);
        check("t5_sel7",   32'(bus.sel),       32'h7);
        check("t5_valid",  32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        push_beats(4'd7, 1);
        wait_drain("t5_drain", 10);
        #1 stop_traffic();
        repeat (2) @(posedge clk);

        // 6: async reset mid-burst on lane 5, then restart from lane 0
        do_reset();
        bus.out_ready = 1'b1;
        bus.req       = 10'h020;
        push_beats(4'd5, 5);
        wait_drain("t6_drain", 20);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_gnt",   32'(bus.gnt),       32'h0);
        check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t6_rst_sel",   32'(bus.sel),       32'h0);
        check("t6_rst_ack",   32'(bus.ack),       32'h0);
        bus.req = 10'h0A1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_beats(4'd0, 1);
        @(posedge clk);
        #1 check("t6_restart_sel", 32'(bus.sel), 32'h0);
        wait_drain("t6_restart_drain", 10);
        #1 stop_traffic();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
